// File: rtl/fpmul_pkg.sv
// fpmul_pkg -- shared definitions for the FP multiplier result packer.
//   * flag-bus bit indices (12-bit auxiliary flag bus)
//   * QNAN constant, EXP_MAX constant
//   * sticky status bit indices {invalid, overflow, underflow, inexact}
//   * stage-2 branch selection enum and helpers
package fpmul_pkg;

  // Flag bus bit map
  localparam int unsigned FL_A_ZERO   = 11;
  localparam int unsigned FL_A_DNF    = 10;
  localparam int unsigned FL_A_INF    = 9;
  localparam int unsigned FL_A_NAN    = 8;
  localparam int unsigned FL_ONES     = 7;
  localparam int unsigned FL_ROUND    = 6;
  localparam int unsigned FL_UNF      = 5;
  localparam int unsigned FL_OVF      = 4;
  localparam int unsigned FL_AB_NAN   = 3;
  localparam int unsigned FL_AB_INF   = 2;
  localparam int unsigned FL_AB_ZERO  = 1;
  localparam int unsigned FL_AB_DNF   = 0;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [8:0]  EXP_MAX = 9'd255;

  // Status bit indices
  localparam int unsigned ST_INVALID   = 3;
  localparam int unsigned ST_OVERFLOW  = 2;
  localparam int unsigned ST_UNDERFLOW = 1;
  localparam int unsigned ST_INEXACT   = 0;

  // Stage-2 result branch, listed in priority order
  typedef enum logic [2:0] {
    SEL_NAN,
    SEL_INF,
    SEL_ZERO,
    SEL_DNF,
    SEL_OVF,
    SEL_UNF,
    SEL_NORM
  } sel_e;

  // Stage-1 payload. Only the low flag bits [5:0] travel to stage 2;
  // bit indices FL_UNF..FL_AB_DNF are valid on this 6-bit slice.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic        round_ovf;
    logic        round_bit;
    logic [5:0]  fl;
  } s1_t;

  function automatic sel_e select_branch(input logic [5:0] fl, input logic round_ovf);
    sel_e sel;
    if (fl[FL_AB_NAN])                  sel = SEL_NAN;
    else if (fl[FL_AB_INF])             sel = SEL_INF;
    else if (fl[FL_AB_ZERO])            sel = SEL_ZERO;
    else if (fl[FL_AB_DNF])             sel = SEL_DNF;
    else if (fl[FL_OVF] || round_ovf)   sel = SEL_OVF;
    else if (fl[FL_UNF])                sel = SEL_UNF;
    else                                sel = SEL_NORM;
    return sel;
  endfunction

  function automatic logic [3:0] status_events(input sel_e sel, input logic round_bit);
    logic [3:0] ev;
    ev = '0;
    case (sel)
      SEL_NAN:  ev[ST_INVALID] = 1'b1;
      SEL_OVF: begin
        ev[ST_OVERFLOW] = 1'b1;
        ev[ST_INEXACT]  = 1'b1;
      end
      SEL_DNF:  ev[ST_UNDERFLOW] = 1'b1;
      SEL_UNF: begin
        ev[ST_UNDERFLOW] = 1'b1;
        ev[ST_INEXACT]   = 1'b1;
      end
      SEL_NORM: ev[ST_INEXACT] = round_bit;
      default:  ev = '0;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/fpmul_round_inc.sv
// fpmul_round_inc -- stage-1 round increment and exponent carry.
// Ports:
//   exp        in  [7:0]  biased exponent before rounding
//   man        in  [22:0] fraction before rounding
//   round_bit  in         round-up request
//   frac_ones  in         fraction is all ones (increment carries out)
//   exp_out    out [7:0]  exponent after rounding
//   frac_out   out [22:0] fraction after rounding
//   round_ovf  out        rounding carried the exponent to EXP_MAX or beyond
module fpmul_round_inc
  import fpmul_pkg::*;
(
  input  logic [7:0]  exp,
  input  logic [22:0] man,
  input  logic        round_bit,
  input  logic        frac_ones,
  output logic [7:0]  exp_out,
  output logic [22:0] frac_out,
  output logic        round_ovf
);

  logic       carry;
  logic [8:0] exp_inc;

  always_comb begin
    carry     = frac_ones & round_bit;
    exp_inc   = {1'b0, exp} + 9'd1;
    frac_out  = man + {22'd0, round_bit};
    exp_out   = exp;
    round_ovf = 1'b0;
    if (carry) begin
      frac_out  = '0;
      exp_out   = exp_inc[7:0];
      round_ovf = (exp_inc >= EXP_MAX);
    end
  end

endmodule

// File: rtl/fpmul_result_pack.sv
// fpmul_result_pack -- 2-stage valid/ready packer for FP multiplier results.
// Stage 1 rounds (fpmul_round_inc), stage 2 selects the special-case
// result and raises status events.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready    upstream handshake
//   sign, exp, man       unrounded product fields
//   flags[11:0]          auxiliary flag bus (see fpmul_pkg)
//   out_valid/out_ready  downstream handshake
//   result[31:0]         IEEE-754 single-precision product
//   status[3:0]          sticky {invalid, overflow, underflow, inexact}
//   status_clr           synchronous clear of status
// Configuration: define FPMUL_STATUS_EN to build the sticky status logic;
// otherwise status reads 0 and status_clr is ignored.
module fpmul_result_pack
  import fpmul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [7:0]  exp,
  input  logic [22:0] man,
  input  logic [11:0] flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  status,
  input  logic        status_clr
);

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_advance;
  s1_t         s1_d;
  s1_t         s1_q;
  logic [7:0]  exp_rnd;
  logic [22:0] frac_rnd;
  logic        rovf;
  sel_e        sel;
  logic [31:0] result_d;
  logic [31:0] result_q;

  // A-operand classification bits are not used by the packer.
  logic unused_flags;
  assign unused_flags = ^flags[11:8];

  assign s1_advance = ~s2_valid | out_ready;
  assign in_ready   = ~s1_valid | s1_advance;

  fpmul_round_inc u_round_inc (
    .exp       (exp),
    .man       (man),
    .round_bit (flags[FL_ROUND]),
    .frac_ones (flags[FL_ONES]),
    .exp_out   (exp_rnd),
    .frac_out  (frac_rnd),
    .round_ovf (rovf)
  );

  always_comb begin
    s1_d           = '0;
    s1_d.sign      = sign;
    s1_d.exp       = exp_rnd;
    s1_d.frac      = frac_rnd;
    s1_d.round_ovf = rovf;
    s1_d.round_bit = flags[FL_ROUND];
    s1_d.fl        = flags[5:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  assign sel = select_branch(s1_q.fl, s1_q.round_ovf);

  always_comb begin
    result_d = '0;
    case (sel)
      SEL_NAN:                    result_d = QNAN;
      SEL_INF, SEL_OVF:           result_d = {s1_q.sign, 8'hFF, 23'd0};
      SEL_ZERO, SEL_DNF, SEL_UNF: result_d = {s1_q.sign, 31'd0};
      SEL_NORM:                   result_d = {s1_q.sign, s1_q.exp, s1_q.frac};
      default:                    result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      result_q <= '0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) result_q <= result_d;
    end
  end

  assign out_valid = s2_valid;
  assign result    = result_q;

`ifdef FPMUL_STATUS_EN
  logic [3:0] ev_d;
  logic [3:0] ev_q;
  logic [3:0] status_q;

  assign ev_d = status_events(sel, s1_q.round_bit);

  // Events ride alongside the stage-2 result and are folded into the
  // sticky register only when that result is consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_q <= '0;
    end else if (s1_advance && s1_valid) begin
      ev_q <= ev_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= '0;
    end else if (s2_valid && out_ready) begin
      status_q <= status_clr ? ev_q : (status_q | ev_q);
    end else if (status_clr) begin
      status_q <= '0;
    end
  end

  assign status = status_q;
`else
  logic unused_status;
  assign unused_status = status_clr ^ s1_q.round_bit;
  assign status        = '0;
`endif

endmodule

// File: tb/tb_fpmul_result_pack.sv
module tb_fpmul_result_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_i;
  logic [7:0]  exp_i;
  logic [22:0] man_i;
  logic [11:0] flags_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  status;
  logic        status_clr;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  ev;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [3:0] exp_status = '0;
  bit         rand_mode = 1'b0;

  always #5 clk = ~clk;

  fpmul_result_pack dut (
    .clk        (clk),
    .rst        (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign       (sign_i),
    .exp        (exp_i),
    .man        (man_i),
    .flags      (flags_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .status     (status),
    .status_clr (status_clr)
  );

  // Reference: IEEE single product packing with flush-to-zero and the
  // stated special-case priority; status events as {inv, ovf, unf, inx}.
  function automatic exp_t model(input logic s, input logic [7:0] e,
                                 input logic [22:0] m, input logic [11:0] f);
    exp_t        r;
    int unsigned ee;
    int unsigned ff;
    bit          rovf;
    ee   = e;
    ff   = (m + f[6]) % (1 << 23);
    rovf = 1'b0;
    if (f[7] && f[6]) begin
      ff   = 0;
      ee   = e + 1;
      rovf = (ee >= 255);
    end
    if (f[3]) begin
      r.res = 32'h7FC0_0000; r.ev = 4'b1000;
    end else if (f[2]) begin
      r.res = {s, 8'hFF, 23'd0}; r.ev = 4'b0000;
    end else if (f[1]) begin
      r.res = {s, 31'd0}; r.ev = 4'b0000;
    end else if (f[0]) begin
      r.res = {s, 31'd0}; r.ev = 4'b0010;
    end else if (f[4] || rovf) begin
      r.res = {s, 8'hFF, 23'd0}; r.ev = 4'b0101;
    end else if (f[5]) begin
      r.res = {s, 31'd0}; r.ev = 4'b0011;
    end else begin
      r.res = {s, ee[7:0], ff[22:0]}; r.ev = {3'b000, f[6]};
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [3:0] ev;
    bit         hs;
    hs = 1'b0;
    ev = '0;
    if (!rst_n) begin
      exp_status = '0;
      sb.delete();
    end else begin
      check("status", {28'd0, status}, {28'd0, exp_status});
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %h required no output at %0t", result, $time);
        end else begin
          check("result", result, sb[0].res);
          if (out_ready) begin
            ev = sb[0].ev;
            void'(sb.pop_front());
            hs = 1'b1;
          end
        end
      end
`ifdef FPMUL_STATUS_EN
      if (hs) exp_status = status_clr ? ev : (exp_status | ev);
      else if (status_clr) exp_status = '0;
`endif
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [22:0] m,
                      input logic [11:0] f, input bit lit, input logic [31:0] litv);
    exp_t x;
    bit   ok;
    x = model(s, e, m, f);
    if (lit) x.res = litv;
    sign_i   = s;
    exp_i    = e;
    man_i    = m;
    flags_i  = f;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (rand_mode) begin
        out_ready  = ($urandom_range(0, 3) != 0);
        status_clr = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(x);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready 0 for 200 cycles required accept");
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      if (rand_mode) begin
        out_ready  = ($urandom_range(0, 3) != 0);
        status_clr = ($urandom_range(0, 7) == 0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] rv;
    logic [11:0] f;
    logic [7:0]  e;
    logic [22:0] m;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    sign_i     = 1'b0;
    exp_i      = '0;
    man_i      = '0;
    flags_i    = '0;
    out_ready  = 1'b1;
    status_clr = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_status", {28'd0, status}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    // Directed vectors
    send(1'b0, 8'h7F, 23'h000000, 12'h000, 1'b1, 32'h3F80_0000);
    send(1'b0, 8'h7F, 23'h7FFFFF, 12'h0C0, 1'b1, 32'h4000_0000);
    send(1'b0, 8'hFE, 23'h7FFFFF, 12'h0C0, 1'b1, 32'h7F80_0000);
    send(1'b1, 8'h00, 23'h000000, 12'h008, 1'b1, 32'h7FC0_0000);
    idle(4);
    status_clr = 1'b1;
    idle(1);
    status_clr = 1'b0;
    idle(2);

    // Back-pressure: two accepts, then in_ready must stay low
    out_ready = 1'b0;
    send(1'b0, 8'h80, 23'h000001, 12'h000, 1'b0, 32'h0);
    send(1'b1, 8'h81, 23'h000002, 12'h040, 1'b0, 32'h0);
    sign_i   = 1'b0;
    exp_i    = 8'h82;
    man_i    = 23'h000003;
    flags_i  = 12'h000;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(1'b0, 8'h82, 23'h000003, 12'h000, 1'b0, 32'h0);
    idle(4);

    // Reset with both stages occupied
    out_ready = 1'b0;
    send(1'b0, 8'h90, 23'h000010, 12'h000, 1'b0, 32'h0);
    send(1'b0, 8'h91, 23'h000011, 12'h000, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_status", {28'd0, status}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("postrst_out_valid", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure and status clears
    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      f  = '0;
      rv = $urandom;
      f[11:8] = rv[3:0];
      f[6] = ($urandom_range(0, 1) == 1);
      f[7] = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 6; b++) f[b] = ($urandom_range(0, 9) == 0);
      rv = $urandom_range(0, 254);
      e  = ($urandom_range(0, 7) == 0) ? 8'hFE : rv[7:0];
      rv = $urandom;
      m  = f[7] ? 23'h7FFFFF : rv[22:0];
      rv = $urandom;
      send(rv[0], e, m, f, 1'b0, 32'h0);
    end
    rand_mode  = 1'b0;
    out_ready  = 1'b1;
    status_clr = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_queue", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpmul_result_pack.md
FPMUL_RESULT_PACK -- requirements
Module: fpmul_result_pack

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state is rising-edge.
REQ-002 SHALL have port rst, input, 1 bit; reset is asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: an upstream operand set is present.
REQ-004 SHALL have port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-005 SHALL have port sign, input, 1 bit: product sign.
REQ-006 SHALL have port exp, input, 8 bits: biased exponent, normalized, not yet rounded.
REQ-007 SHALL have port man, input, 23 bits: fraction, not yet rounded.
REQ-008 SHALL have port flags, input, 12 bits: auxiliary flag bus.
- Bit map: [11] A zero, [10] A denormal, [9] A inf, [8] A NaN, [7] fraction all-ones, [6] round, [5] underflow, [4] overflow, [3] AB_NAN, [2] AB_INF, [1] AB_ZERO, [0] AB_DNF.
REQ-009 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port result, output, 32 bits: IEEE-754 single-precision product.
REQ-012 SHALL have port status, output, 4 bits: sticky {invalid, overflow, underflow, inexact}.
REQ-013 SHALL have port status_clr, input, 1 bit: synchronous clear of status.

Function
REQ-014 SHALL be a 2-stage valid/ready pipeline.
- An operand set is accepted when in_valid & in_ready.
- A result is consumed when out_valid & out_ready.
REQ-015 SHALL give a latency of 2 cycles from accept to out_valid, and a throughput of 1 per cycle while out_ready=1.
REQ-016 in_ready SHALL be ~s1_valid | s1_advance; s1_advance is ~s2_valid | out_ready.
REQ-017 While out_valid=1 and out_ready=0, result SHALL hold stable; no operand set SHALL be dropped or reordered.
REQ-018 Stage 1 SHALL perform the round step:
- frac = man + flags[6].
- If flags[7] & flags[6]: frac = 0 and exp + 1.
- If exp + 1 == 255, a round-overflow condition SHALL be raised.
REQ-019 Stage 2 SHALL select the result by this priority:
- AB_NAN gives 0x7FC00000.
- AB_INF gives {sign, 0xFF, 0}.
- AB_ZERO gives {sign, 0}.
- AB_DNF gives {sign, 0}; the input is flushed to zero.
- flags[4] or round-overflow gives {sign, 0xFF, 0}.
- flags[5] gives {sign, 0}.
- Otherwise gives {sign, exp, frac} after the round step.
REQ-020 Status events SHALL be raised as follows:
- invalid = AB_NAN.
- overflow = the overflow branch is selected.
- underflow = the AB_DNF or underflow branch is selected.
- inexact = flags[6] on the normal branch, or the overflow or underflow branch.
REQ-021 Status events SHALL be OR-ed into status only on output handshake.
REQ-022 When status_clr and a handshake occur in the same cycle, the new event bits SHALL be set and all other bits cleared.

Reset
REQ-023 While rst=0, the block SHALL asynchronously hold out_valid=0, result=0, status=0, and all stage valid bits=0.
- in_ready SHALL be 1 after reset.
REQ-024 Asserting reset mid-operation SHALL discard all in-flight results without emitting them.

Configuration
REQ-025 With FPMUL_STATUS_EN defined, status and status_clr SHALL be as specified.
- Without it, status SHALL be tied to 0, status_clr ignored, and no status flops SHALL be inferred.
- result and the handshake SHALL be identical in both cases.

Structure
REQ-026 Shared package fpmul_pkg SHALL hold:
- flag-bit index constants;
- the QNAN constant 0x7FC00000;
- status bit indices;
- the EXP_MAX constant 255.
REQ-027 The stage-1 round-increment and exponent-carry logic SHALL be the sub-module fpmul_round_inc.

Verification
REQ-028 sign=0, exp=0x7F, man=0, flags=0 -> result 0x3F800000 two cycles later; status 0.
REQ-029 exp=0x7F, man=0x7FFFFF, flags[7]=flags[6]=1 -> result 0x40000000; inexact set.
REQ-030 exp=0xFE, man=0x7FFFFF, flags[7]=flags[6]=1 -> result 0x7F800000; overflow and inexact set.
REQ-031 sign=1, flags[3]=1 -> result 0x7FC00000; invalid set; then status_clr pulse -> status 0.
REQ-032 Three back-to-back inputs with out_ready=0 for 3 cycles -> in_ready drops after 2 accepts; outputs stable and in order.
REQ-033 rst=0 pulse with both stages valid -> out_valid 0 immediately; status 0; no result emitted.
